// File: rtl/debug_snapshot_streamer_if.sv
// Snapshot request/TX byte bundle between the debug controller (master) and the streamer (slave).
// Carries capture inputs, UART TX valid/ready byte handshake and status flags.
interface debug_snapshot_streamer_if #(
  parameter int NUM_WORDS  = 8,
  parameter int WORD_WIDTH = 32
);
  logic                            snap_req;
  logic [NUM_WORDS*WORD_WIDTH-1:0] snap_data;
  logic [NUM_WORDS-1:0]            word_mask;
  logic                            clr_overrun;
  logic                            tx_ready;
  logic                            tx_valid;
  logic [7:0]                      tx_byte;
  logic                            busy;
  logic                            done;
  logic                            overrun;

  modport master (
    output snap_req, snap_data, word_mask, clr_overrun, tx_ready,
    input  tx_valid, tx_byte, busy, done, overrun
  );

  modport slave (
    input  snap_req, snap_data, word_mask, clr_overrun, tx_ready,
    output tx_valid, tx_byte, busy, done, overrun
  );
endinterface

// File: rtl/debug_snapshot_streamer.sv
// Captures NUM_WORDS latch words on snap_req and streams HDR,CNT,{IDX,DATA..},CHK; header valid 1 cycle after request.
// tx_byte holds while tx_valid && !tx_ready; requests while busy or on the done cycle are dropped and flag overrun.
module debug_snapshot_streamer #(
  parameter int          NUM_WORDS   = 8,
  parameter int          WORD_WIDTH  = 32,
  parameter int          BYTE_ORDER  = 0,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
  input  logic                       clk,
  input  logic                       reset,
  debug_snapshot_streamer_if.slave   bus
);

  localparam int         BPW       = (WORD_WIDTH + 7) / 8;
  localparam int         WEXT      = BPW * 8;
  localparam int         DW        = NUM_WORDS * WORD_WIDTH;
  localparam logic [15:0] LAST_BYTE = 16'(BPW - 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_CNT, S_IDX, S_DATA, S_CHK} state_t;

  state_t               state_q, state_d;
  logic [DW-1:0]        shadow_data_q, shadow_data_d;
  logic [NUM_WORDS-1:0] shadow_mask_q, shadow_mask_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [7:0]           rem_q, rem_d;
  logic [7:0]           idx_q, idx_d;
  logic [7:0]           scan_q, scan_d;
  logic [15:0]          byte_cnt_q, byte_cnt_d;
  logic [7:0]           chk_q, chk_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 overrun_q, overrun_d;

  logic [7:0]           req_cnt;
  logic [WORD_WIDTH-1:0] word_sel;
  logic [WEXT-1:0]      word_ext;
  logic                 mask_hit;
  logic                 accept;
  logic [7:0]           first_b;
  logic [7:0]           next_b;

  function automatic logic [7:0] byte_of(input logic [WEXT-1:0] w, input logic [15:0] k);
    int sel;
    sel = (BYTE_ORDER == 0) ? int'(k) : (BPW - 1 - int'(k));
    return 8'(w >> (sel * 8));
  endfunction

  always_comb begin
    req_cnt = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      req_cnt = req_cnt + 8'(bus.word_mask[i]);
    end
  end

  assign word_sel = WORD_WIDTH'(shadow_data_q >> (idx_q * WORD_WIDTH));
  assign word_ext = WEXT'(word_sel);
  assign mask_hit = 1'(shadow_mask_q >> scan_q);
  assign accept   = tx_valid_q && bus.tx_ready;
  assign first_b  = byte_of(word_ext, 16'd0);
  assign next_b   = byte_of(word_ext, byte_cnt_q + 16'd1);

  always_comb begin
    state_d       = state_q;
    shadow_data_d = shadow_data_q;
    shadow_mask_d = shadow_mask_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    idx_d         = idx_q;
    scan_d        = scan_q;
    byte_cnt_d    = byte_cnt_q;
    chk_d         = chk_q;
    tx_valid_d    = tx_valid_q;
    tx_byte_d     = tx_byte_q;
    busy_d        = busy_q;
    done_d        = 1'b0;

    // The done cycle still counts as occupied so a back-to-back request is rejected.
    if (bus.snap_req && (busy_q || done_q)) begin
      overrun_d = 1'b1;
    end else if (bus.clr_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.snap_req && !done_q) begin
          shadow_data_d = bus.snap_data;
          shadow_mask_d = bus.word_mask;
          cnt_d         = req_cnt;
          rem_d         = req_cnt;
          chk_d         = 8'h00;
          tx_valid_d    = 1'b1;
          tx_byte_d     = HEADER_BYTE;
          busy_d        = 1'b1;
          state_d       = S_HDR;
        end
      end
      S_HDR: begin
        if (accept) begin
          tx_byte_d = cnt_q;
          chk_d     = cnt_q;
          state_d   = S_CNT;
        end
      end
      S_CNT: begin
        if (accept) begin
          if (rem_q == 8'd0) begin
            tx_byte_d = chk_q;
            state_d   = S_CHK;
          end else begin
            tx_valid_d = 1'b0;
            scan_d     = 8'd0;
            state_d    = S_IDX;
          end
        end
      end
      S_IDX: begin
        // tx_valid low means still scanning; one mask bit examined per cycle.
        if (!tx_valid_q) begin
          if (mask_hit) begin
            tx_valid_d = 1'b1;
            tx_byte_d  = scan_q;
            idx_d      = scan_q;
            chk_d      = chk_q ^ scan_q;
            rem_d      = rem_q - 8'd1;
          end else begin
            scan_d = scan_q + 8'd1;
          end
        end else if (accept) begin
          byte_cnt_d = 16'd0;
          tx_byte_d  = first_b;
          chk_d      = chk_q ^ first_b;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          if (byte_cnt_q != LAST_BYTE) begin
            byte_cnt_d = byte_cnt_q + 16'd1;
            tx_byte_d  = next_b;
            chk_d      = chk_q ^ next_b;
          end else if (rem_q != 8'd0) begin
            tx_valid_d = 1'b0;
            scan_d     = idx_q + 8'd1;
            state_d    = S_IDX;
          end else begin
            tx_byte_d = chk_q;
            state_d   = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (accept) begin
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      shadow_data_q <= '0;
      shadow_mask_q <= '0;
      cnt_q         <= '0;
      rem_q         <= '0;
      idx_q         <= '0;
      scan_q        <= '0;
      byte_cnt_q    <= '0;
      chk_q         <= '0;
      tx_valid_q    <= 1'b0;
      tx_byte_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_data_q <= shadow_data_d;
      shadow_mask_q <= shadow_mask_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      idx_q         <= idx_d;
      scan_q        <= scan_d;
      byte_cnt_q    <= byte_cnt_d;
      chk_q         <= chk_d;
      tx_valid_q    <= tx_valid_d;
      tx_byte_q     <= tx_byte_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_byte  = tx_byte_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_debug_snapshot_streamer.sv
// Two streamer instances (32-bit LSB-first, 12-bit MSB-first) driven by shared random stimulus.
// Expected frames come from a byte-list model; a negedge monitor pops and compares accepted bytes.
module tb_debug_snapshot_streamer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  debug_snapshot_streamer_if #(.NUM_WORDS(4), .WORD_WIDTH(32)) ifa ();
  debug_snapshot_streamer_if #(.NUM_WORDS(4), .WORD_WIDTH(12)) ifb ();

  debug_snapshot_streamer #(.NUM_WORDS(4), .WORD_WIDTH(32), .BYTE_ORDER(0), .HEADER_BYTE(8'hA5)) dut_a (
    .clk(clk), .reset(rst_n), .bus(ifa.slave));
  debug_snapshot_streamer #(.NUM_WORDS(4), .WORD_WIDTH(12), .BYTE_ORDER(1), .HEADER_BYTE(8'hA5)) dut_b (
    .clk(clk), .reset(rst_n), .bus(ifb.slave));

  int          vectors = 0;
  int          miscompares = 0;
  bit          open [2];
  bit          ovr_m [2];
  bit          pend_done [2];
  bit          hold_v [2];
  logic [7:0]  hold_b [2];
  int          acc_cnt [2];
  logic [8:0]  q0 [$];
  logic [8:0]  q1 [$];

  task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s.%s: actual %0h required %0h at %0t", (d == 0) ? "A" : "B", name, act, exp, $time);
    end
  endtask

  // Frame = A5, popcount, then per enabled word its index and BPW bytes, then XOR of everything after A5.
  task automatic push_frame(input int d, input logic [127:0] data, input logic [3:0] mask);
    int ww, bo, bpw, sh;
    logic [127:0] w;
    logic [7:0] fr [$];
    logic [7:0] x;
    ww  = (d == 0) ? 32 : 12;
    bo  = (d == 0) ? 0 : 1;
    bpw = (ww + 7) / 8;
    fr.push_back(8'hA5);
    fr.push_back(8'($countones(mask)));
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        fr.push_back(8'(i));
        w = (data >> (i * ww)) & ((128'(1) << ww) - 128'(1));
        for (int k = 0; k < bpw; k++) begin
          sh = (bo == 1) ? (bpw - 1 - k) : k;
          fr.push_back(8'(w >> (8 * sh)));
        end
      end
    end
    x = 8'h00;
    for (int j = 1; j < fr.size(); j++) x = x ^ fr[j];
    fr.push_back(x);
    for (int j = 0; j < fr.size(); j++) begin
      if (d == 0) q0.push_back({j == fr.size() - 1, fr[j]});
      else        q1.push_back({j == fr.size() - 1, fr[j]});
    end
  endtask

  task automatic mon(input int d, input logic vld, input logic rdy, input logic [7:0] byt,
                     input logic dn, input logic bsy, input logic ovr);
    logic [8:0] e;
    bit empty;
    chk(d, "done", 32'(dn), 32'(pend_done[d]));
    if (pend_done[d]) open[d] = 1'b0;
    pend_done[d] = 1'b0;
    chk(d, "busy", 32'(bsy), 32'(open[d]));
    chk(d, "overrun", 32'(ovr), 32'(ovr_m[d]));
    if (hold_v[d]) begin
      chk(d, "hold_valid", 32'(vld), 32'd1);
      chk(d, "hold_byte", 32'(byt), 32'(hold_b[d]));
    end
    if (vld && rdy) begin
      hold_v[d] = 1'b0;
      acc_cnt[d]++;
      empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        vectors++;
        miscompares++;
        $display("FAIL %s.unexpected_byte: actual %0h required none", (d == 0) ? "A" : "B", byt);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk(d, "tx_byte", 32'(byt), 32'(e[7:0]));
        pend_done[d] = e[8];
      end
    end else begin
      hold_v[d] = vld;
      hold_b[d] = byt;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, ifa.tx_valid, ifa.tx_ready, ifa.tx_byte, ifa.done, ifa.busy, ifa.overrun);
      mon(1, ifb.tx_valid, ifb.tx_ready, ifb.tx_byte, ifb.done, ifb.busy, ifb.overrun);
    end
  end

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [47:0] rnd48();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[47:0];
  endfunction

  // Called at posedge+1; drives one cycle of inputs, then applies the model after the sampling edge.
  task automatic step(input bit req, input bit clr, input bit rdy, input logic [127:0] da,
                      input logic [47:0] db, input logic [3:0] ma, input logic [3:0] mb);
    bit acc [2];
    ifa.snap_req = req; ifa.snap_data = da; ifa.word_mask = ma; ifa.clr_overrun = clr; ifa.tx_ready = rdy;
    ifb.snap_req = req; ifb.snap_data = db; ifb.word_mask = mb; ifb.clr_overrun = clr; ifb.tx_ready = rdy;
    for (int d = 0; d < 2; d++) acc[d] = req && !open[d];
    @(posedge clk);
    #1;
    ifa.snap_req = 1'b0; ifa.clr_overrun = 1'b0;
    ifb.snap_req = 1'b0; ifb.clr_overrun = 1'b0;
    if (acc[0]) begin push_frame(0, da, ma); open[0] = 1'b1; end
    if (acc[1]) begin push_frame(1, 128'(db), mb); open[1] = 1'b1; end
    for (int d = 0; d < 2; d++) begin
      if (req && !acc[d]) ovr_m[d] = 1'b1;
      else if (clr)       ovr_m[d] = 1'b0;
    end
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, rdy, rnd128(), rnd48(), 4'($urandom()), 4'($urandom()));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((open[0] || open[1]) && n < 400) begin
      idle(1'b1);
      n++;
    end
    vectors++;
    if (open[0] || open[1]) begin
      miscompares++;
      $display("FAIL drain_timeout: frames open A=%0d B=%0d after %0d cycles, required none", open[0], open[1], n);
    end
  endtask

  task automatic wait_acc(input int target);
    int n;
    n = 0;
    while (acc_cnt[0] < target && n < 100) begin
      idle(1'b1);
      n++;
    end
    chk(0, "acc_reached", 32'(acc_cnt[0] >= target), 32'd1);
  endtask

  logic [127:0] da_t1;
  logic [47:0]  db_t1;
  int           base;

  initial begin
    rst_n = 1'b0;
    ifa.snap_req = 1'b0; ifa.snap_data = '0; ifa.word_mask = '0; ifa.clr_overrun = 1'b0; ifa.tx_ready = 1'b0;
    ifb.snap_req = 1'b0; ifb.snap_data = '0; ifb.word_mask = '0; ifb.clr_overrun = 1'b0; ifb.tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk(0, "rst_tx_valid", 32'(ifa.tx_valid), 32'd0);
    chk(0, "rst_tx_byte",  32'(ifa.tx_byte),  32'd0);
    chk(0, "rst_busy",     32'(ifa.busy),     32'd0);
    chk(0, "rst_done",     32'(ifa.done),     32'd0);
    chk(0, "rst_overrun",  32'(ifa.overrun),  32'd0);
    chk(1, "rst_tx_valid", 32'(ifb.tx_valid), 32'd0);
    chk(1, "rst_busy",     32'(ifb.busy),     32'd0);
    rst_n = 1'b1;
    idle(1'b1);

    da_t1 = {32'h0, 32'h0, 32'hAABBCCDD, 32'h11223344};
    db_t1 = 48'h000ABC000000;
    step(1'b1, 1'b0, 1'b1, da_t1, db_t1, 4'b0011, 4'b0100);
    drain();

    base = acc_cnt[0];
    step(1'b1, 1'b0, 1'b1, da_t1, db_t1, 4'b0011, 4'b0100);
    wait_acc(base + 3);
    repeat (5) begin
      idle(1'b0);
      chk(0, "stall_valid", 32'(ifa.tx_valid), 32'd1);
      chk(0, "stall_byte",  32'(ifa.tx_byte),  32'h44);
    end
    drain();

    step(1'b1, 1'b0, 1'b1, rnd128(), rnd48(), 4'b0000, 4'b0000);
    drain();

    step(1'b1, 1'b0, 1'b1, rnd128(), rnd48(), 4'hF, 4'hF);
    idle(1'b1);
    idle(1'b1);
    step(1'b1, 1'b0, 1'b1, rnd128(), rnd48(), 4'hF, 4'hF);
    step(1'b1, 1'b1, 1'b1, rnd128(), rnd48(), 4'hF, 4'hF);
    idle(1'b1);
    step(1'b0, 1'b1, 1'b1, rnd128(), rnd48(), 4'hF, 4'hF);
    drain();

    repeat (600) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
           rnd128(), rnd48(), 4'($urandom()), 4'($urandom()));
    end
    drain();

    base = acc_cnt[0];
    step(1'b1, 1'b0, 1'b1, rnd128(), rnd48(), 4'hF, 4'hF);
    idle(1'b1);
    step(1'b1, 1'b0, 1'b1, rnd128(), rnd48(), 4'hF, 4'hF);
    wait_acc(base + 5);
    chk(0, "ovr_before_reset", 32'(ifa.overrun), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk(0, "async_rst_tx_valid", 32'(ifa.tx_valid), 32'd0);
    chk(0, "async_rst_busy",     32'(ifa.busy),     32'd0);
    chk(0, "async_rst_overrun",  32'(ifa.overrun),  32'd0);
    chk(1, "async_rst_tx_valid", 32'(ifb.tx_valid), 32'd0);
    chk(1, "async_rst_busy",     32'(ifb.busy),     32'd0);
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      open[d] = 1'b0; ovr_m[d] = 1'b0; pend_done[d] = 1'b0; hold_v[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1, rnd128(), rnd48(), 4'($urandom()), 4'($urandom()));
    drain();

    chk(0, "leftover_bytes", 32'(q0.size()), 32'd0);
    chk(1, "leftover_bytes", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
